if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entry count; power of two, minimum 2.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  fetch offers an entry.
REQ-005 SHALL have port in_ready  output  1  queue accepts an entry this cycle.
REQ-006 SHALL have port in_pc  input  32  PC of the offered instruction.
REQ-007 SHALL have port in_instr  input  32  offered instruction word.
REQ-008 SHALL have port in_exc  input  1  fetch exception for the offered entry.
REQ-009 SHALL have port flush  input  1  discard all entries (branch, jump or interrupt redirect).
REQ-010 SHALL have port out_valid  output  1  head entry available to decode.
REQ-011 SHALL have port out_ready  input  1  decode consumes the head entry.
REQ-012 SHALL have ports out_pc  output  32, out_instr  output  32 and out_exc  output  1: head entry fields.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  number of stored entries.

Function
REQ-014 SHALL enqueue when in_valid and in_ready are both high at a clock edge; SHALL dequeue when out_valid and out_ready are both high.
REQ-015 SHALL drive in_ready = (count < DEPTH) and not exc_lock; no combinational dependence on out_ready.
REQ-016 SHALL drive out_valid = (count != 0); out_pc, out_instr and out_exc SHALL come from the head entry, and SHALL be 0 when out_valid = 0.
REQ-017 SHALL have enqueue-to-out_valid latency of exactly 1 cycle; no combinational in-to-out bypass.
REQ-018 SHALL, on simultaneous enqueue and dequeue, hold count unchanged and advance both pointers.
REQ-019 SHALL hold in_ready = 0 when full, even if out_ready = 1 in the same cycle.
REQ-020 SHALL keep head and tail pointers at log2(DEPTH) bits, wrapping modulo DEPTH.
REQ-021 SHALL set exc_lock when an entry with in_exc = 1 is enqueued; while exc_lock is set, no further entries SHALL be accepted; draining SHALL continue.
REQ-022 SHALL, when flush is high at an edge, set count, pointers and exc_lock to 0; flush SHALL take priority over an enqueue or dequeue in the same cycle, and both SHALL be discarded.
REQ-023 SHALL keep out_valid at 1 in the flush cycle; it SHALL go to 0 on the following cycle.
REQ-024 SHALL never underflow or overflow count; a dequeue attempt when empty SHALL be impossible by construction.

Reset
REQ-025 SHALL, on reset assertion and independent of clk, set count = 0, pointers = 0 and exc_lock = 0; out_valid = 0, in_ready = 1, out_pc, out_instr and out_exc = 0.
REQ-026 SHALL discard all entries when reset is asserted mid-operation; storage contents need no reset.
REQ-027 SHALL accept the first entry on the first edge after reset deasserts.

Configuration
REQ-028 SHALL, when macro IF_ID_QUEUE_PREDECODE_EN is defined, add outputs out_is_branch (opcode 1100011) and out_is_jump (opcode 1101111 or 1100111); both 1 bit.
REQ-029 SHALL compute predecode bits at enqueue from in_instr[6:0] and store them per entry; no added latency; bits SHALL be 0 when out_valid = 0.
REQ-030 SHALL omit these ports and their storage when IF_ID_QUEUE_PREDECODE_EN is undefined; all other behaviour SHALL be identical.

Verification
REQ-031 SHALL test fill: DEPTH=4, enqueue PCs 0x0/0x4/0x8/0xC with out_ready=0 -> count=4, in_ready=0, out_pc=0x0.
REQ-032 SHALL test full with simultaneous offer: queue full, out_ready=1, in_valid=1 -> the offer is not accepted; count=3 next cycle; the next PC 0x10 is accepted the cycle after.
REQ-033 SHALL test wrap-around: stream 10 entries with out_ready=1 -> outputs in order PC 0x0..0x24, each 1 cycle after enqueue, and count never above 1.
REQ-034 SHALL test flush: 3 entries queued, flush=1 with in_valid=1 (PC 0x40) -> count=0 and out_valid=0 next cycle; PC 0x40 is never output.
REQ-035 SHALL test exception lock: enqueue PC 0x100 with in_exc=1 -> in_ready=0 until flush; out_exc=1 with out_pc=0x100 at the head.
REQ-036 SHALL test predecode (with macro defined): enqueue 0x00000063 then 0x0000006F -> out_is_branch=1, then out_is_jump=1.

Source files
------------

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO of {pc, instr, exc} with flush and
// exception lock. Define IF_ID_QUEUE_PREDECODE_EN to add per-entry branch/jump predecode outputs.
module if_id_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     in_exc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_exc,
  output logic [$clog2(DEPTH):0]   count
`ifdef IF_ID_QUEUE_PREDECODE_EN
  ,
  output logic                     out_is_branch,
  output logic                     out_is_jump
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];
  logic          r_exc_mem   [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_exc_lock;

  logic w_push;
  logic w_pop;

  assign in_ready  = (r_count < CW'(DEPTH)) && !r_exc_lock;
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  // Flush discards any simultaneous enqueue/dequeue.
  assign w_push = in_valid && in_ready && !flush;
  assign w_pop  = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_exc_lock <= 1'b0;
    end else if (flush) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_exc_lock <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
        if (in_exc) begin
          r_exc_lock <= 1'b1;
        end
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; validity is tracked solely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_tail]    <= in_pc;
      r_instr_mem[r_tail] <= in_instr;
      r_exc_mem[r_tail]   <= in_exc;
    end
  end

  always_comb begin
    out_pc    = '0;
    out_instr = '0;
    out_exc   = 1'b0;
    if (out_valid) begin
      out_pc    = r_pc_mem[r_head];
      out_instr = r_instr_mem[r_head];
      out_exc   = r_exc_mem[r_head];
    end
  end

`ifdef IF_ID_QUEUE_PREDECODE_EN
  logic r_br_mem  [DEPTH];
  logic r_jmp_mem [DEPTH];
  logic w_in_br;
  logic w_in_jmp;

  assign w_in_br  = (in_instr[6:0] == 7'b1100011);
  assign w_in_jmp = (in_instr[6:0] == 7'b1101111) || (in_instr[6:0] == 7'b1100111);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_br_mem[r_tail]  <= w_in_br;
      r_jmp_mem[r_tail] <= w_in_jmp;
    end
  end

  always_comb begin
    out_is_branch = 1'b0;
    out_is_jump   = 1'b0;
    if (out_valid) begin
      out_is_branch = r_br_mem[r_head];
      out_is_jump   = r_jmp_mem[r_head];
    end
  end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=4); predecode checks run when
// IF_ID_QUEUE_PREDECODE_EN is defined.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_exc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc;
  logic [2:0]  count;
`ifdef IF_ID_QUEUE_PREDECODE_EN
  logic        out_is_branch;
  logic        out_is_jump;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_exc    (in_exc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_exc   (out_exc),
    .count     (count)
`ifdef IF_ID_QUEUE_PREDECODE_EN
    ,
    .out_is_branch (out_is_branch),
    .out_is_jump   (out_is_jump)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc, input logic exc);
    in_valid = v;
    in_pc    = pc;
    in_instr = pc ^ 32'hA5A5_0000;
    in_exc   = exc;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    offer(1'b0, 32'h0, 1'b0);
    #2;
    check("rst_count", 32'(count), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_exc", 32'(out_exc), 0);
    @(negedge clk);
    reset = 1'b0;

    // Fill
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 32'(i * 4), 1'b0);
      step();
      if (i == 0) begin
        check("fill_lat_valid", 32'(out_valid), 1);
        check("fill_lat_instr", out_instr, 32'hA5A5_0000);
      end
    end
    check("fill_count", 32'(count), 4);
    check("fill_in_ready", 32'(in_ready), 0);
    check("fill_out_pc", out_pc, 32'h0);

    // Full with simultaneous offer: offer refused, dequeue proceeds
    offer(1'b1, 32'h10, 1'b0);
    out_ready = 1'b1;
    check("full_in_ready_or1", 32'(in_ready), 0);
    step();
    check("full_count3", 32'(count), 3);
    check("full_head_pc", out_pc, 32'h4);
    out_ready = 1'b0;
    check("full_in_ready_again", 32'(in_ready), 1);
    step();
    check("full_accept_count", 32'(count), 4);
    offer(1'b0, 32'h0, 1'b0);
    out_ready = 1'b1;
    step();
    check("drain_pc8", out_pc, 32'h8);
    step();
    check("drain_pcC", out_pc, 32'hC);
    step();
    check("drain_pc10", out_pc, 32'h10);
    check("drain_instr10", out_instr, 32'hA5A5_0010);
    step();
    check("drain_empty_count", 32'(count), 0);
    check("drain_empty_valid", 32'(out_valid), 0);
    check("drain_empty_pc", out_pc, 0);

    // Wrap-around streaming
    for (int i = 0; i < 10; i++) begin
      offer(1'b1, 32'(i * 4), 1'b0);
      step();
      check($sformatf("wrap_pc%0d", i), out_pc, 32'(i * 4));
      check($sformatf("wrap_cnt%0d", i), 32'(count), 1);
    end
    offer(1'b0, 32'h0, 1'b0);
    step();
    check("wrap_end_count", 32'(count), 0);

    // Flush with a concurrent offer and dequeue
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 32'h30 + 32'(i * 4), 1'b0);
      step();
    end
    check("flush_pre_count", 32'(count), 3);
    offer(1'b1, 32'h40, 1'b0);
    flush     = 1'b1;
    out_ready = 1'b1;
    check("flush_cycle_valid", 32'(out_valid), 1);
    step();
    flush = 1'b0;
    offer(1'b0, 32'h0, 1'b0);
    check("flush_count", 32'(count), 0);
    check("flush_out_valid", 32'(out_valid), 0);
    check("flush_in_ready", 32'(in_ready), 1);
    step();
    check("flush_no_pc40", 32'(out_valid), 0);

    // Exception lock
    out_ready = 1'b0;
    offer(1'b1, 32'h100, 1'b1);
    step();
    check("exc_in_ready", 32'(in_ready), 0);
    check("exc_out_exc", 32'(out_exc), 1);
    check("exc_out_pc", out_pc, 32'h100);
    offer(1'b1, 32'h104, 1'b0);
    step();
    step();
    check("exc_lock_count", 32'(count), 1);
    out_ready = 1'b1;
    step();
    check("exc_drain_count", 32'(count), 0);
    check("exc_drain_in_ready", 32'(in_ready), 0);
    check("exc_drain_out_exc", 32'(out_exc), 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    offer(1'b0, 32'h0, 1'b0);
    check("exc_unlock", 32'(in_ready), 1);

    // Asynchronous reset mid-operation, then first edge accepts
    out_ready = 1'b0;
    offer(1'b1, 32'h180, 1'b0);
    step();
    step();
    offer(1'b0, 32'h0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_count", 32'(count), 0);
    check("async_rst_valid", 32'(out_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    offer(1'b1, 32'h200, 1'b0);
    step();
    check("post_rst_valid", 32'(out_valid), 1);
    check("post_rst_pc", out_pc, 32'h200);
    offer(1'b0, 32'h0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;

`ifdef IF_ID_QUEUE_PREDECODE_EN
    check("pd_empty_branch", 32'(out_is_branch), 0);
    in_valid = 1'b1;
    in_pc    = 32'h300;
    in_instr = 32'h0000_0063;
    in_exc   = 1'b0;
    step();
    in_pc    = 32'h304;
    in_instr = 32'h0000_006F;
    step();
    in_valid = 1'b0;
    check("pd_branch", 32'(out_is_branch), 1);
    check("pd_branch_nojump", 32'(out_is_jump), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pd_jump", 32'(out_is_jump), 1);
    check("pd_jump_nobranch", 32'(out_is_branch), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
